// File: rtl/intra_neighbor_buffer.sv
// Intra-prediction neighbour buffer: walks a frame of 4x4 blocks in raster order,
// presenting top/left reconstructed neighbours and storing each reconstructed block's edges.
module intra_neighbor_buffer #(
  parameter int FRAME_W_BLKS = 8,
  parameter int FRAME_H_BLKS = 8,
  localparam int XW = (FRAME_W_BLKS > 1) ? $clog2(FRAME_W_BLKS) : 1,
  localparam int YW = (FRAME_H_BLKS > 1) ? $clog2(FRAME_H_BLKS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  output logic          nbr_valid,
  input  logic          nbr_ready,
  output logic [31:0]   top_neighbors,
  output logic [31:0]   left_neighbors,
  output logic          top_available,
  output logic          left_available,
  input  logic          recon_valid,
  output logic          recon_ready,
  input  logic [127:0]  recon_block,
  output logic [XW-1:0] blk_x,
  output logic [YW-1:0] blk_y,
  output logic          frame_done,
  output logic [2:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // nbr_valid holds with stable data until taken, recon_ready is high only while waiting.

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_PRESENT    = 3'd2,
    S_WAIT_RECON = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W_BLKS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H_BLKS - 1);
  localparam logic [31:0]   NBR_DEFAULT = {4{8'd128}};

  state_t        r_state;
  state_t        w_next;
  logic [XW-1:0] r_blk_x;
  logic [YW-1:0] r_blk_y;
  logic [31:0]   r_top_nbr;
  logic [31:0]   r_left_nbr;
  logic          r_top_av;
  logic          r_left_av;
  logic [31:0]   r_line_buf [FRAME_W_BLKS];
  logic [31:0]   r_left_col;

  logic          w_capture;
  logic          w_last_x;
  logic          w_last_y;
  logic [31:0]   w_left_col;

  assign w_capture = (r_state == S_WAIT_RECON) && recon_valid && !frame_start;
  assign w_last_x  = (r_blk_x == X_LAST);
  assign w_last_y  = (r_blk_y == Y_LAST);
  // Column 3 of the block, row 0 in the low byte.
  assign w_left_col = {recon_block[127:120], recon_block[95:88],
                       recon_block[63:56],   recon_block[31:24]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    nbr_valid   = 1'b0;
    recon_ready = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE:    w_next = r_state;
      S_FETCH:   w_next = S_PRESENT;
      S_PRESENT: begin
        nbr_valid = 1'b1;
        if (nbr_ready) w_next = S_WAIT_RECON;
      end
      S_WAIT_RECON: begin
        recon_ready = 1'b1;
        if (recon_valid) w_next = (w_last_x && w_last_y) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_done = !frame_start;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A new frame start overrides everything, including an in-flight capture.
    if (frame_start) w_next = S_FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_x    <= '0;
      r_blk_y    <= '0;
      r_top_nbr  <= '0;
      r_left_nbr <= '0;
      r_top_av   <= 1'b0;
      r_left_av  <= 1'b0;
    end else if (frame_start) begin
      r_blk_x <= '0;
      r_blk_y <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_top_av   <= (r_blk_y != '0);
        r_left_av  <= (r_blk_x != '0);
        r_top_nbr  <= (r_blk_y != '0) ? r_line_buf[r_blk_x] : NBR_DEFAULT;
        r_left_nbr <= (r_blk_x != '0) ? r_left_col : NBR_DEFAULT;
      end
      if (w_capture) begin
        if (w_last_x) begin
          r_blk_x <= '0;
          if (!w_last_y) r_blk_y <= r_blk_y + 1'b1;
        end else begin
          r_blk_x <= r_blk_x + 1'b1;
        end
      end
    end
  end

  // Edge storage is never cleared; availability masking hides stale contents.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_line_buf[r_blk_x] <= recon_block[127:96];
      r_left_col          <= w_left_col;
    end
  end

  assign top_neighbors  = r_top_nbr;
  assign left_neighbors = r_left_nbr;
  assign top_available  = r_top_av;
  assign left_available = r_left_av;
  assign blk_x          = r_blk_x;
  assign blk_y          = r_blk_y;
  assign dbg_state      = r_state;

endmodule

// File: doc/intra_neighbor_buffer.md
INTRA_NEIGHBOR_BUFFER -- requirements
Module: intra_neighbor_buffer

Interface
REQ-001 SHALL have parameter FRAME_W_BLKS, default 8, frame width in 4x4 blocks (2..256).
REQ-002 SHALL have parameter FRAME_H_BLKS, default 8, frame height in 4x4 blocks (1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse; (re)starts the frame at block (0,0).
REQ-006 SHALL have port nbr_valid  output  1  neighbour set for current block is presented.
REQ-007 SHALL have port nbr_ready  input  1  prediction stage accepts the neighbour set.
REQ-008 SHALL have port top_neighbors  output  4x8  pixels above the current block, index 0 = leftmost.
REQ-009 SHALL have port left_neighbors  output  4x8  pixels left of the current block, index 0 = top.
REQ-010 SHALL have port top_available  output  1  top_neighbors hold reconstructed data.
REQ-011 SHALL have port left_available  output  1  left_neighbors hold reconstructed data.
REQ-012 SHALL have port recon_valid  input  1  reconstructed block for the current position is offered.
REQ-013 SHALL have port recon_ready  output  1  block accepts the reconstructed block.
REQ-014 SHALL have port recon_block  input  4x4x8  reconstructed pixels, [row][col].
REQ-015 SHALL have port blk_x  output  clog2(FRAME_W_BLKS)  current block column.
REQ-016 SHALL have port blk_y  output  clog2(FRAME_H_BLKS)  current block row.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after the last block is stored.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, PRESENT, WAIT_RECON, DONE.
REQ-019 IDLE SHALL go to FETCH on frame_start, clearing blk_x and blk_y to 0.
REQ-020 FETCH SHALL last exactly one cycle, reading the top line buffer at blk_x, then go to PRESENT.
REQ-021 PRESENT SHALL drive nbr_valid=1 with stable data until nbr_valid and nbr_ready are both high, then go to WAIT_RECON.
REQ-022 WAIT_RECON SHALL drive recon_ready=1; on recon_valid it SHALL capture the block and advance.
REQ-023 On capture, the top line buffer entry at blk_x SHALL be written with recon_block row 3, cols 0..3.
REQ-024 On capture, the left column register SHALL be written with recon_block col 3, rows 0..3.
REQ-025 Advance SHALL be raster order: blk_x+1; at FRAME_W_BLKS-1, blk_x wraps to 0 and blk_y increments; next state is FETCH.
REQ-026 Capture at (FRAME_W_BLKS-1, FRAME_H_BLKS-1) SHALL go to DONE; DONE SHALL assert frame_done for one cycle and then go to IDLE.
REQ-027 top_available SHALL be (blk_y!=0); left_available SHALL be (blk_x!=0); both SHALL be valid whenever nbr_valid=1.
REQ-028 An unavailable neighbour array SHALL output 8'd128 on all four entries.
REQ-029 The line buffer SHALL hold FRAME_W_BLKS x 4 x 8 bits and SHALL NOT be cleared at frame_start; availability masking alone guarantees correctness.
REQ-030 frame_start in any state other than IDLE SHALL abort the frame: blk_x=blk_y=0, next state FETCH, no frame_done pulse, and a same-cycle recon capture discarded.
REQ-031 nbr_valid SHALL be asserted only in PRESENT; recon_ready only in WAIT_RECON; the two SHALL never be high together.
REQ-032 Per-block throughput SHALL be at most 3 cycles with nbr_ready and recon_valid held high: FETCH, PRESENT, WAIT_RECON.

Reset
REQ-033 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0, including blk_x, blk_y, frame_done, nbr_valid, recon_ready, both availability flags and both neighbour arrays. Line buffer contents are don't-care.
REQ-034 Reset asserted mid-frame SHALL take effect immediately (asynchronous). After release, the block SHALL wait in IDLE for frame_start.

Verification
REQ-035 The bench SHALL cover each scenario below.
- 2x2-block frame, recon block b with all pixels = 10*(b+1), handshakes always ready: block (0,0) -> both arrays 128, flags 0. Block (1,0) -> left = 10, top = 128. Block (0,1) -> top = 10, left = 128. Block (1,1) -> top = 20, left = 30. frame_done pulses once, 1 cycle after the 4th capture.
- Backpressure: nbr_ready held low 5 cycles -> nbr_valid and the neighbour data stay stable for 5 cycles. recon_valid delayed 3 cycles -> blk_x and blk_y do not change until capture.
- Row wrap, FRAME_W_BLKS=8: capture at (7,0) -> next block is (0,1), left_available=0, left = 128.
- frame_start asserted during WAIT_RECON at (3,2) -> next nbr_valid is at (0,0) with both flags 0, no frame_done, and stale line-buffer data never appears.
- rst asserted during PRESENT -> nbr_valid=0 in the same cycle. After release, the outputs stay at their reset values until frame_start arrives.
